scalar_mult_ctrl: RTL and testbench

Sequencer that computes R = k·P on the Ed448 datapath by driving one shared `point_add` unit through a constant-time, MSB-first double-and-add schedule. It is a controller only: it holds the accumulator and base point, issues operands and `start` pulses to the adder, and captures the adder's results. It sits between the signing/verification top level and `point_add`. All coordinates are projective (X, Y, Z) in the Montgomery domain used by `point_add`.

---
 rtl/scalar_mult_ctrl.sv | 157 +++++++++++++++
 tb/tb_scalar_mult_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/scalar_mult_ctrl.sv
// Constant-time MSB-first double-and-add sequencer for k*P.
// It drives one shared point_add unit and holds Q, B, S and the result R.
module scalar_mult_ctrl #(
    parameter int DATA_WIDTH   = 448,
    parameter int SCALAR_WIDTH = 448,
    parameter logic [DATA_WIDTH-1:0] ID_X = '0,
    parameter logic [DATA_WIDTH-1:0] ID_Y = (DATA_WIDTH'(1) << 224) | DATA_WIDTH'(1),
    parameter logic [DATA_WIDTH-1:0] ID_Z = (DATA_WIDTH'(1) << 224) | DATA_WIDTH'(1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [SCALAR_WIDTH-1:0] scalar,
    input  logic [DATA_WIDTH-1:0]   Px,
    input  logic [DATA_WIDTH-1:0]   Py,
    input  logic [DATA_WIDTH-1:0]   Pz,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   Rx,
    output logic [DATA_WIDTH-1:0]   Ry,
    output logic [DATA_WIDTH-1:0]   Rz,
    output logic                    pa_start,
    output logic [DATA_WIDTH-1:0]   pa_X1,
    output logic [DATA_WIDTH-1:0]   pa_Y1,
    output logic [DATA_WIDTH-1:0]   pa_Z1,
    output logic [DATA_WIDTH-1:0]   pa_X2,
    output logic [DATA_WIDTH-1:0]   pa_Y2,
    output logic [DATA_WIDTH-1:0]   pa_Z2,
    input  logic [DATA_WIDTH-1:0]   pa_X3,
    input  logic [DATA_WIDTH-1:0]   pa_Y3,
    input  logic [DATA_WIDTH-1:0]   pa_Z3,
    input  logic                    pa_done
);

    localparam int CW = (SCALAR_WIDTH > 1) ? $clog2(SCALAR_WIDTH) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DBL   = 3'd1;
    localparam logic [2:0] S_DBL_W = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_ADD_W = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    logic [2:0]                  state_q, state_d;
    logic [2:0][DATA_WIDTH-1:0]  acc_q, acc_d;
    logic [2:0][DATA_WIDTH-1:0]  base_q, base_d;
    logic [2:0][DATA_WIDTH-1:0]  res_q, res_d;
    logic [SCALAR_WIDTH-1:0]     s_q, s_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        guard_q, guard_d;
    logic [2:0][DATA_WIDTH-1:0]  pa_res;
    logic                        pa_ok;

    assign pa_res = {pa_Z3, pa_Y3, pa_X3};
    // The first cycle of each wait state masks pa_done so a stale level is never taken as a result.
    assign pa_ok  = pa_done && !guard_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        base_d  = base_q;
        res_d   = res_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        guard_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = {Pz, Py, Px};
                    acc_d   = {ID_Z, ID_Y, ID_X};
                    s_d     = scalar;
                    cnt_d   = CW'(SCALAR_WIDTH - 1);
                    state_d = S_DBL;
                end
            end
            S_DBL: begin
                guard_d = 1'b1;
                state_d = S_DBL_W;
            end
            S_DBL_W: begin
                if (pa_ok) begin
                    acc_d   = pa_res;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                guard_d = 1'b1;
                state_d = S_ADD_W;
            end
            S_ADD_W: begin
                if (pa_ok) begin
                    // The add is always issued; a zero bit simply discards its result.
                    if (s_q[SCALAR_WIDTH-1]) begin
                        acc_d = pa_res;
                    end
                    if (cnt_q == '0) begin
                        res_d   = s_q[SCALAR_WIDTH-1] ? pa_res : acc_q;
                        state_d = S_FIN;
                    end else begin
                        s_d     = s_q << 1;
                        cnt_d   = cnt_q - 1'b1;
                        state_d = S_DBL;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            base_q  <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            guard_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            base_q  <= base_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            guard_q <= guard_d;
        end
    end

    assign busy     = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done     = (state_q == S_FIN);
    assign pa_start = (state_q == S_DBL) || (state_q == S_ADD);
    assign Rx       = res_q[0];
    assign Ry       = res_q[1];
    assign Rz       = res_q[2];

    // Second operand is B during the add phase and Q otherwise (doubling).
    always_comb begin
        pa_X1 = acc_q[0];
        pa_Y1 = acc_q[1];
        pa_Z1 = acc_q[2];
        pa_X2 = acc_q[0];
        pa_Y2 = acc_q[1];
        pa_Z2 = acc_q[2];
        if ((state_q == S_ADD) || (state_q == S_ADD_W)) begin
            pa_X2 = base_q[0];
            pa_Y2 = base_q[1];
            pa_Z2 = base_q[2];
        end
    end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Scoreboard bench for scalar_mult_ctrl with a componentwise-add mock adder (ID = 0, so R = k*P).
module tb_scalar_mult_ctrl;

    localparam int W = 32;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] scalar = '0;
    logic [W-1:0] Px = '0, Py = '0, Pz = '0;
    logic         busy, done;
    logic [W-1:0] Rx, Ry, Rz;
    logic         pa_start;
    logic [W-1:0] pa_X1, pa_Y1, pa_Z1, pa_X2, pa_Y2, pa_Z2;
    logic [W-1:0] pa_X3 = '0, pa_Y3 = '0, pa_Z3 = '0;
    logic         pa_done = 1'b0;

    scalar_mult_ctrl #(
        .DATA_WIDTH(W), .SCALAR_WIDTH(N),
        .ID_X('0), .ID_Y('0), .ID_Z('0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .scalar(scalar),
        .Px(Px), .Py(Py), .Pz(Pz),
        .busy(busy), .done(done), .Rx(Rx), .Ry(Ry), .Rz(Rz),
        .pa_start(pa_start),
        .pa_X1(pa_X1), .pa_Y1(pa_Y1), .pa_Z1(pa_Z1),
        .pa_X2(pa_X2), .pa_Y2(pa_Y2), .pa_Z2(pa_Z2),
        .pa_X3(pa_X3), .pa_Y3(pa_Y3), .pa_Z3(pa_Z3),
        .pa_done(pa_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Mock adder: latency lat, pulse or level-held done.
    int lat = 3;
    bit level_mode = 1'b0;
    int mcnt = 0;
    always @(posedge clk) begin
        if (pa_start) begin
            pa_X3   <= pa_X1 + pa_X2;
            pa_Y3   <= pa_Y1 + pa_Y2;
            pa_Z3   <= pa_Z1 + pa_Z2;
            pa_done <= 1'b0;
            mcnt    <= 1;
        end else if (mcnt > 0) begin
            mcnt <= mcnt + 1;
            if (mcnt == lat - 1) pa_done <= 1'b1;
            else if (!level_mode) pa_done <= 1'b0;
        end else if (!level_mode) begin
            pa_done <= 1'b0;
        end
    end

    typedef struct {
        logic [W-1:0] x, y, z;
        int acc;
        int latency;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    int  npa = 0;
    bit  done_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            npa = 0;
            done_prev = 1'b0;
        end else begin
            if (pa_start) npa++;
            if (done_prev) check("done_one_cycle", done, 0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("Rx", Rx, e.x);
                    check("Ry", Ry, e.y);
                    check("Rz", Rz, e.z);
                    check("latency", cyc - e.acc, e.latency);
                    check("pa_start_count", npa, 2 * N);
                    check("busy_at_done", busy, 0);
                end
                npa = 0;
            end
            done_prev = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [N-1:0] k, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] z, input int abort_at, input int inject_at);
        exp_t e;
        int acc;
        scalar = k; Px = x; Py = y; Pz = z; start = 1'b1;
        acc = cyc;
        if (abort_at < 0) begin
            e.x = W'(longint'(k) * longint'(x));
            e.y = W'(longint'(k) * longint'(y));
            e.z = W'(longint'(k) * longint'(z));
            e.acc = acc;
            e.latency = 1 + 2 * N * (lat + 1);
            sb.push_back(e);
        end
        tick();
        start = 1'b0;
        scalar = $urandom; Px = $urandom; Py = $urandom; Pz = $urandom;
        if (abort_at >= 0) begin
            while (cyc < acc + abort_at) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check("abort_busy", busy, 0);
            check("abort_pa_start", pa_start, 0);
            check("abort_R", {Rx, Ry, Rz}, 0);
            repeat (2 * lat + 4) tick();
            check("abort_no_done", done, 0);
            return;
        end
        if (inject_at >= 0) begin
            while (cyc < acc + inject_at) tick();
            check("busy_before_inject", busy, 1);
            scalar = 8'hFF; Px = 32'h1111; Py = 32'h2222; Pz = 32'h3333; start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int t = 0; t < 4000 && sb.size() > 0; t++) tick();
        if (sb.size() > 0) begin
            check("timeout_waiting_done", 0, 1);
            sb.delete();
        end
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pa_start", pa_start, 0);
        check("reset_R", {Rx, Ry, Rz}, 0);
        check("reset_operands", {pa_X1, pa_Y1, pa_Z1, pa_X2, pa_Y2, pa_Z2}, 0);
        tick();

        lat = 3; level_mode = 1'b0;
        run(8'h05, 32'd1, 32'd2, 32'd3, -1, -1);
        run(8'hFF, 32'd1, 32'd1, 32'd1, -1, -1);
        level_mode = 1'b1;
        run(8'h00, 32'd7, 32'd8, 32'd9, -1, -1);
        level_mode = 1'b0;
        tick();
        run(8'h05, 32'd1, 32'd2, 32'd3, 20, -1);
        run(8'h03, 32'd2, 32'd0, 32'd1, -1, 10);
        check("R_held_after_done", Rz, 3);

        for (int i = 0; i < 6; i++) begin
            lat = $urandom_range(2, 5);
            level_mode = $urandom_range(0, 1);
            tick();
            run(N'($urandom), $urandom, $urandom, $urandom, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
